cordic_sincos_seq: RTL and testbench

- Iterative rotation-mode CORDIC; the inverse of the team's combinational vectoring-mode arctan block.
- Takes an angle in degrees and returns cos and sin, one micro-rotation per clock, behind a start/busy/done handshake.
- The input angle format is the arctan block's output format (signed Q8.24 degrees), so the two blocks chain directly.

---
 rtl/cordic_pkg.sv | 32 +++
 rtl/cordic_rot_step.sv | 35 +++
 rtl/cordic_sincos_seq.sv | 113 +++++++++++
 tb/tb_cordic_sincos_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC constants (arctan table, gain, angle limits) and FSM state type
package cordic_pkg;

  // atan(2^-i) in degrees, 8.32 fixed point
  localparam logic signed [39:0] ATAN_TBL [32] = '{
    40'sd193273528320, 40'sd114096026022, 40'sd60285206653,  40'sd30601712202,
    40'sd15360239180,  40'sd7687607525,   40'sd3844741810,   40'sd1922488225,
    40'sd961258780,    40'sd480631223,    40'sd240315841,    40'sd120157949,
    40'sd60078978,     40'sd30039490,     40'sd15019745,     40'sd7509872,
    40'sd3754936,      40'sd1877468,      40'sd938734,       40'sd469367,
    40'sd234684,       40'sd117342,       40'sd58671,        40'sd29335,
    40'sd14668,        40'sd7334,         40'sd3667,         40'sd1833,
    40'sd917,          40'sd458,          40'sd229,          40'sd115
  };

  localparam int     K_Q30  = 652032874;
  localparam longint DEG90  = 64'sd386547056640;
  localparam longint DEG180 = 64'sd773094113280;

  typedef enum logic [1:0] {IDLE, ROT, FIN} state_t;

  function automatic logic signed [31:0] sat32(input longint v);
    if (v > 64'sd2147483647) begin
      return 32'sh7FFFFFFF;
    end else if (v < -64'sd2147483648) begin
      return 32'sh80000000;
    end else begin
      return v[31:0];
    end
  endfunction

endpackage

// File: rtl/cordic_rot_step.sv
// rtl/cordic_rot_step.sv - one combinational rotation-mode CORDIC micro-rotation
module cordic_rot_step #(
  parameter int XW = 34,
  parameter int ZW = 40
) (
  input  logic signed [XW-1:0] x_i,
  input  logic signed [XW-1:0] y_i,
  input  logic signed [ZW-1:0] z_i,
  input  logic        [4:0]    shift_i,
  input  logic signed [ZW-1:0] atan_i,
  output logic signed [XW-1:0] x_o,
  output logic signed [XW-1:0] y_o,
  output logic signed [ZW-1:0] z_o
);

  logic signed [XW-1:0] xs;
  logic signed [XW-1:0] ys;

  assign xs = x_i >>> shift_i;
  assign ys = y_i >>> shift_i;

  // z == 0 rotates positively so every iteration contributes
  always_comb begin
    if (z_i[ZW-1]) begin
      x_o = x_i + ys;
      y_o = y_i - xs;
      z_o = z_i + atan_i;
    end else begin
      x_o = x_i - ys;
      y_o = y_i + xs;
      z_o = z_i - atan_i;
    end
  end

endmodule

// File: rtl/cordic_sincos_seq.sv
// rtl/cordic_sincos_seq.sv - iterative rotation-mode CORDIC producing cos/sin of a Q8.24 degree angle
module cordic_sincos_seq
  import cordic_pkg::*;
#(
  parameter int ITER = 32,
  parameter int ZW   = 40,
  parameter int XW   = 34
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [31:0] angle,
  output logic               busy,
  output logic               done,
  output logic signed [31:0] cos_out,
  output logic signed [31:0] sin_out
);

  state_t               state_q;
  logic [5:0]           iter_q;
  logic                 busy_q;
  logic                 done_q;
  logic signed [31:0]   cos_q;
  logic signed [31:0]   sin_q;
  logic signed [XW-1:0] x_q, y_q, x_d, y_d;
  logic signed [ZW-1:0] z_q, z_d;
  logic                 neg_q;

  logic signed [ZW-1:0] a_w, z0_w, deg90_w, deg180_w, atan_w;
  logic                 neg0_w;

  assign deg90_w  = ZW'(DEG90);
  assign deg180_w = ZW'(DEG180);
  assign atan_w   = ZW'(ATAN_TBL[iter_q[4:0]]);

  // Fold into [-90, 90]; the 180 deg offset wraps in ZW bits but the result is in range
  always_comb begin
    a_w    = ZW'(angle) <<< 8;
    z0_w   = a_w;
    neg0_w = 1'b0;
    if (a_w > deg90_w) begin
      z0_w   = a_w - deg180_w;
      neg0_w = 1'b1;
    end else if (a_w < -deg90_w) begin
      z0_w   = a_w + deg180_w;
      neg0_w = 1'b1;
    end
  end

  cordic_rot_step #(.XW(XW), .ZW(ZW)) u_step (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .shift_i(iter_q[4:0]),
    .atan_i (atan_w),
    .x_o    (x_d),
    .y_o    (y_d),
    .z_o    (z_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      neg_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q     <= XW'(K_Q30);
            y_q     <= '0;
            z_q     <= z0_w;
            neg_q   <= neg0_w;
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ROT;
          end
        end
        ROT: begin
          x_q    <= x_d;
          y_q    <= y_d;
          z_q    <= z_d;
          iter_q <= iter_q + 6'd1;
          if (iter_q == 6'(ITER - 1)) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          cos_q   <= sat32(neg_q ? -longint'(x_q) : longint'(x_q));
          sin_q   <= sat32(neg_q ? -longint'(y_q) : longint'(y_q));
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign cos_out = cos_q;
  assign sin_out = sin_q;

endmodule

// File: tb/tb_cordic_sincos_seq.sv
// tb/tb_cordic_sincos_seq.sv - self-checking bench for cordic_sincos_seq
module tb_cordic_sincos_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] angle = '0;
  logic        busy;
  logic        done;
  logic [31:0] cos_out;
  logic [31:0] sin_out;

  always #5 clk = ~clk;

  cordic_sincos_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .angle  (angle),
    .busy   (busy),
    .done   (done),
    .cos_out(cos_out),
    .sin_out(sin_out)
  );

  typedef struct {
    logic [31:0] ang;
    int          ec;
    int          es;
  } vec_t;

  typedef struct {
    int ec;
    int es;
  } exp_t;

  localparam int TOL = 16;

  exp_t sb[$];
  vec_t vecs[12];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_done = 0;

  task automatic check(input string name, input int act, input int req, input int tol);
    int diff;
    n_cmp++;
    diff = act - req;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, req, tol);
    end
  endtask

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  function automatic vec_t mk(input logic [31:0] a);
    vec_t v;
    real  rad;
    rad   = ($itor($signed(a)) / 16777216.0) * 3.14159265358979323846 / 180.0;
    v.ang = a;
    v.ec  = rnd($cos(rad) * 1073741824.0);
    v.es  = rnd($sin(rad) * 1073741824.0);
    return v;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1, want no done");
      end else begin
        e = sb.pop_front();
        check("cos_out", $signed(cos_out), e.ec, TOL);
        check("sin_out", $signed(sin_out), e.es, TOL);
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after the accept edge
  task automatic start_op(input logic [31:0] a, input int ec, input int es);
    exp_t e;
    start = 1'b1;
    angle = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    angle = ~a;
    e.ec = ec;
    e.es = es;
    sb.push_back(e);
    check("busy_after_accept", int'(busy), 1, 0);
  endtask

  task automatic wait_done(input string name, input int already);
    int lat;
    lat = already;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    check({name, "_latency"}, lat, 33, 0);
    check({name, "_busy_at_done"}, int'(busy), 0, 0);
  endtask

  initial begin
    int d0;

    vecs[0]  = '{32'h00000000, 1073741824, 0};
    vecs[1]  = '{32'h1E000000, 929887697, 536870912};
    vecs[2]  = '{32'hA6000000, 0, -1073741824};
    vecs[3]  = '{32'h78000000, -536870912, 929887697};
    vecs[4]  = '{32'h88000000, -536870912, -929887697};
    vecs[5]  = '{32'h5A000000, 0, 1073741824};
    vecs[6]  = '{32'h2D000000, 759250125, 759250125};
    vecs[7]  = mk(32'h80000000);
    vecs[8]  = mk(32'h7FFFFFFF);
    vecs[9]  = mk(32'h5A000001);
    vecs[10] = mk(32'hA5FFFFFF);
    vecs[11] = mk(32'h96000000);

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0, 0);
    check("reset_done", int'(done), 0, 0);
    check("reset_cos", $signed(cos_out), 0, 0);
    check("reset_sin", $signed(sin_out), 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].ang, vecs[i].ec, vecs[i].es);
      wait_done($sformatf("vec%0d", i), 0);
      @(posedge clk);
      #1;
    end

    // start during rotation is ignored; start in the done cycle is accepted
    start_op(32'h1E000000, 929887697, 536870912);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    angle = 32'h3C000000;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore", 5);
    start_op(32'hE2000000, 929887697, -536870912);
    wait_done("b2b", 0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_cos", $signed(cos_out), 929887697, TOL);
    check("hold_sin", $signed(sin_out), -536870912, TOL);

    // reset mid-rotation discards the operation
    start_op(32'h2D000000, 759250125, 759250125);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_busy", int'(busy), 0, 0);
    check("midrst_done", int'(done), 0, 0);
    check("midrst_cos", $signed(cos_out), 0, 0);
    check("midrst_sin", $signed(sin_out), 0, 0);
    d0 = n_done;
    repeat (40) @(posedge clk);
    #1;
    check("midrst_no_done", n_done, d0, 0);
    start_op(32'hD3000000, 759250125, -759250125);
    wait_done("after_rst", 0);
    @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
